// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_MISALIGN_TRAP_EN adds the HALT state used by the misaligned-redirect trap.
package fetch_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        StFetch,
        StDrain,
        StHalt
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        StFetch,
        StDrain
    } fetch_state_t;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {instr, pc} entries; flush beats push and pop.
// Head entry is presented combinationally so decode sees it with zero latency.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so push at full is legal then.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited imem reads, buffers
// returned words and applies redirects by killing in-flight responses. FETCH_MISALIGN_TRAP_EN
// enables the misaligned-redirect trap (HALT state, sticky misalign_err).
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misalign_err
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_d;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_d;
    logic [31:0]   r_rsp_pc;
    logic [31:0]   w_rsp_pc_d;
    logic [CW-1:0] r_out;
    logic [CW-1:0] w_out_d;
    logic [CW-1:0] r_kill;
    logic [CW-1:0] w_kill_d;

    logic          w_req_fire;
    logic          w_credit;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_empty;
    logic          w_fifo_full_unused;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic          r_err;
    logic          w_err_d;
`else
    logic          w_unused_tgt_lsbs;
    assign w_unused_tgt_lsbs = ^redirect_target[1:0];
`endif

    // Credit counts buffered words plus words still owed by memory, so the FIFO never overflows.
    assign w_credit       = ({1'b0, w_count} + {1'b0, r_out}) < DEPTH_W;
    assign imem_req_valid = rst_n & (r_state == StFetch) & w_credit & ~redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign instr_valid    = ~w_empty;
    assign w_pop          = instr_valid & instr_ready;
    assign instruction    = instr_valid ? w_head.instr : 32'h0;
    assign instr_pc       = instr_valid ? w_head.pc : 32'h0;
    assign instr_pc_plus4 = instr_valid ? (w_head.pc + PC_STEP) : 32'h0;

    assign w_push_entry.instr = imem_rsp_data;
    assign w_push_entry.pc    = r_rsp_pc;

    always_comb begin
        w_state_d  = r_state;
        w_pc_d     = r_pc;
        w_rsp_pc_d = r_rsp_pc;
        w_kill_d   = r_kill;
        w_push     = 1'b0;
        w_flush    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_err_d    = r_err;
`endif
        w_out_d    = r_out + CW'(w_req_fire) - CW'(imem_rsp_valid);

        if (w_req_fire) begin
            w_pc_d = r_pc + PC_STEP;
        end

        // r_rsp_pc is the PC of the next surviving response; responses return in order.
        if (imem_rsp_valid) begin
            if (r_kill != '0) begin
                w_kill_d = r_kill - CW'(1);
            end else begin
                w_push     = 1'b1;
                w_rsp_pc_d = r_rsp_pc + PC_STEP;
            end
        end

        if (r_state == StDrain && w_kill_d == '0) begin
            w_state_d = StFetch;
        end

        if (redirect_valid) begin
            w_flush    = 1'b1;
            w_push     = 1'b0;
            w_pc_d     = align_word(redirect_target);
            w_rsp_pc_d = align_word(redirect_target);
            w_kill_d   = w_out_d;
            w_state_d  = (w_out_d != '0) ? StDrain : StFetch;
`ifdef FETCH_MISALIGN_TRAP_EN
            w_err_d = |redirect_target[1:0];
            if (w_err_d) begin
                w_state_d = StHalt;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StFetch;
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_out    <= '0;
            r_kill   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_pc     <= w_pc_d;
            r_rsp_pc <= w_rsp_pc_d;
            r_out    <= w_out_d;
            r_kill   <= w_kill_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_err    <= w_err_d;
`endif
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_err = r_err;
`else
    assign misalign_err = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_fifo_full_unused),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then random traffic against a
// program-order reference (sequential PCs from the last redirect, words = hash of address).
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        misalign_err;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] mem_addr_q [$];
    int          mem_due_q [$];
    logic [31:0] acc_log [$];
    logic [31:0] dlv_log [$];
    logic [31:0] fetch_pc = RESET_PC;
    logic [31:0] exp_pc = RESET_PC;
    bit          halted = 1'b0;
    bit          err_exp = 1'b0;
    bit          prev_hold = 1'b0;
    bit          cur_req_ready = 1'b0;
    bit          cur_instr_ready = 1'b0;
    bit          saw_rdr_cond = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample #1 later, then advance the reference.
    task automatic tick(input bit rdr, input logic [31:0] tgt, input bit cond);
        bit fire;
        bit pop;
        bit do_rdr;
        int d;
        @(negedge clk);
        imem_req_ready = cur_req_ready;
        instr_ready    = cur_instr_ready;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_addr_q[0]);
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        do_rdr = rdr;
        if (cond) begin
            do_rdr = instr_valid && imem_rsp_valid;
            if (do_rdr) saw_rdr_cond = 1'b1;
        end
        redirect_valid  = do_rdr;
        redirect_target = tgt;
        #1;
        chk("misalign_err", misalign_err, err_exp);
        if (prev_hold) chk("hold_valid", instr_valid, 1);
        if (halted) begin
            chk("halt_req", imem_req_valid, 0);
            chk("halt_instr", instr_valid, 0);
        end
        if (do_rdr) chk("rdr_noreq", imem_req_valid, 0);
        if (instr_valid) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instruction", instruction, word_of(exp_pc));
            chk("instr_pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
        end
        fire = imem_req_valid && imem_req_ready;
        pop  = instr_valid && instr_ready;
        if (fire) begin
            chk("req_addr", imem_req_addr, fetch_pc);
            acc_log.push_back(imem_req_addr);
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(d);
            fetch_pc = fetch_pc + 32'd4;
            chk("credit", mem_addr_q.size() <= DEPTH, 1);
        end
        if (pop && !do_rdr) begin
            dlv_log.push_back(instr_pc);
            exp_pc = exp_pc + 32'd4;
        end
        prev_hold = instr_valid && !instr_ready && !do_rdr;
        if (do_rdr) begin
            fetch_pc = tgt & ~32'h3;
            exp_pc   = tgt & ~32'h3;
`ifdef FETCH_MISALIGN_TRAP_EN
            halted  = (tgt[1:0] != 2'b00);
            err_exp = halted;
`endif
        end
        cyc++;
    endtask

    initial begin
        int base;
        int r;
        logic [31:0] tgt;

        // Reset values
        #12;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_pc_plus4", instr_pc_plus4, 0);
        chk("rst_misalign", misalign_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: streaming from reset, 1-cycle memory
        cur_req_ready = 1'b1;
        cur_instr_ready = 1'b1;
        lat_min = 1;
        lat_max = 1;
        repeat (12) tick(1'b0, 32'h0, 1'b0);
        chk("p1_acc_n", acc_log.size() >= 3, 1);
        chk("p1_dlv_n", dlv_log.size() >= 3, 1);
        if (acc_log.size() >= 3 && dlv_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("p1_req_seq", acc_log[i], RESET_PC + 32'(4 * i));
                chk("p1_pc_seq", dlv_log[i], RESET_PC + 32'(4 * i));
            end
        end

        // 2: decode stall fills the buffer and blocks requests
        cur_instr_ready = 1'b0;
        repeat (10) tick(1'b0, 32'h0, 1'b0);
        chk("p2_req_blocked", imem_req_valid, 0);
        chk("p2_valid_held", instr_valid, 1);
        cur_instr_ready = 1'b1;
        base = dlv_log.size();
        repeat (10) tick(1'b0, 32'h0, 1'b0);
        chk("p2_drained", (dlv_log.size() - base) >= 2, 1);

        // 3: redirect with two slow requests in flight
        lat_min = 3;
        lat_max = 3;
        tick(1'b1, 32'h10, 1'b0);
        for (int i = 0; i < 12 && mem_addr_q.size() != 2; i++) tick(1'b0, 32'h0, 1'b0);
        chk("p3_inflight", mem_addr_q.size(), 2);
        if (mem_addr_q.size() == 2) begin
            chk("p3_inflight0", mem_addr_q[0], 32'h10);
            chk("p3_inflight1", mem_addr_q[1], 32'h14);
        end
        base = acc_log.size();
        tick(1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 30 && !instr_valid; i++) tick(1'b0, 32'h0, 1'b0);
        chk("p3_got_instr", instr_valid, 1);
        chk("p3_first_pc", instr_pc, 32'h100);
        chk("p3_next_req_n", acc_log.size() > base, 1);
        if (acc_log.size() > base) chk("p3_next_req", acc_log[base], 32'h100);

        // 4: redirect colliding with a pop and an arriving response
        lat_min = 1;
        lat_max = 1;
        tick(1'b1, 32'h300, 1'b0);
        for (int i = 0; i < 40 && !saw_rdr_cond; i++) tick(1'b0, 32'h400, 1'b1);
        chk("p4_collision_seen", saw_rdr_cond, 1);
        tick(1'b0, 32'h0, 1'b0);
        chk("p4_flushed", instr_valid, 0);
        base = dlv_log.size();
        repeat (12) tick(1'b0, 32'h0, 1'b0);
        chk("p4_resumed", dlv_log.size() > base, 1);
        if (dlv_log.size() > base) chk("p4_first_pc", dlv_log[base], 32'h400);

        // 5: PC wraps past the top of the address space
        base = acc_log.size();
        tick(1'b1, 32'hFFFF_FFF8, 1'b0);
        repeat (16) tick(1'b0, 32'h0, 1'b0);
        chk("p5_acc_n", acc_log.size() >= base + 3, 1);
        if (acc_log.size() >= base + 3) begin
            chk("p5_req_top", acc_log[base + 1], 32'hFFFF_FFFC);
            chk("p5_req_wrap", acc_log[base + 2], 32'h0000_0000);
        end

        // 6: misaligned redirect
        base = acc_log.size();
        tick(1'b1, 32'h102, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (20) tick(1'b0, 32'h0, 1'b0);
        chk("p6_err_set", misalign_err, 1);
        chk("p6_no_req", acc_log.size(), base);
        base = acc_log.size();
        tick(1'b1, 32'h200, 1'b0);
        repeat (10) tick(1'b0, 32'h0, 1'b0);
        chk("p6_err_clear", misalign_err, 0);
        chk("p6_resume_n", acc_log.size() > base, 1);
        if (acc_log.size() > base) chk("p6_resume_addr", acc_log[base], 32'h200);
`else
        repeat (10) tick(1'b0, 32'h0, 1'b0);
        chk("p6_err_tied", misalign_err, 0);
        chk("p6_fetch_n", acc_log.size() > base, 1);
        if (acc_log.size() > base) chk("p6_fetch_addr", acc_log[base], 32'h100);
`endif

        // 7: random traffic against the reference
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            cur_req_ready   = ($urandom_range(3, 0) != 0);
            cur_instr_ready = ($urandom_range(1, 0) != 0);
            r = int'($urandom_range(99, 0));
            if (r < 4) begin
                tgt = $urandom;
                if ($urandom_range(3, 0) != 0) tgt[1:0] = 2'b00;
                if (r == 0) tgt = 32'hFFFF_FFF0;
                tick(1'b1, tgt, 1'b0);
            end else begin
                tick(1'b0, 32'h0, 1'b0);
            end
        end

        // 8: forward progress after an aligned redirect
        cur_req_ready = 1'b1;
        cur_instr_ready = 1'b1;
        tick(1'b1, 32'h800, 1'b0);
        base = dlv_log.size();
        repeat (24) tick(1'b0, 32'h0, 1'b0);
        chk("p8_progress", (dlv_log.size() - base) >= 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end that produces the 32-bit instruction stream consumed by the control unit and datapath decode stage.
- Owns the PC and issues word reads to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Applies PCSrc-driven redirects (branch/JAL), flushing wrong-path instructions, including words still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, instruction FIFO entries; also the maximum outstanding requests (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  read data returned; in order; ≥1 cycle after acceptance; no backpressure
- imem_rsp_data  in  32  returned instruction word
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode consumes instruction
- instruction  out  32  instruction word (control unit input)
- instr_pc  out  32  PC of presented instruction
- instr_pc_plus4  out  32  instr_pc + 4 (JAL link value)
- redirect_valid  in  1  PCSrc asserted by execute
- redirect_target  in  32  branch/jump target
- misalign_err  out  1  see Optional Feature; tied 0 when compiled out

Behaviour:
- Reset (async assert, sync deassert expected): PC=RESET_PC; FIFO empty; outstanding=0; kill=0; state=FETCH; every output 0 except imem_req_addr=RESET_PC.
- imem_req_addr = PC. imem_req_valid = (state==FETCH) && (count+outstanding < DEPTH) && !redirect_valid.
- Request accepted (valid&&ready): PC += 4 (mod 2^32; 0xFFFF_FFFC wraps to 0); outstanding++.
- Response: outstanding--. If kill>0, word dropped and kill--. Otherwise word and its PC (tracked by an in-flight PC queue or fetch-PC counter) written to FIFO. Credit rule guarantees no overflow.
- Decode side: instr_valid = FIFO non-empty. Pop on instr_valid&&instr_ready. Outputs are FIFO head, zero-latency. Stable while valid && !ready.
- Minimum latency: response written cycle N, instr_valid high cycle N+1.
- Same cycle push+pop: allowed at full and at empty. Count unchanged.
- Redirect (redirect_valid=1, highest priority):
  - FIFO flushed; any pop in the same cycle is void.
  - kill = outstanding minus responses arriving this cycle.
  - PC = {redirect_target[31:2],2'b00}.
  - No request issued that cycle.
  - If resulting kill>0, state=DRAIN, else FETCH.
- DRAIN: no requests. Return to FETCH the cycle after kill reaches 0. Fetch resumes from target.
- Redirect during DRAIN: PC retargeted, kill re-accumulated identically. Last redirect wins.
- States: FETCH, DRAIN. The encoding is an enum.
- Reset mid-transaction: all state cleared. Responses to pre-reset requests are the memory's responsibility to suppress.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined: redirect with target[1:0]!=0 sets sticky misalign_err and enters state HALT.
  - HALT: no requests, FIFO flushed, in-flight responses dropped.
  - Only a subsequent aligned redirect clears misalign_err and resumes (via DRAIN/FETCH rules).
- Undefined: low bits silently cleared; misalign_err=0; no HALT state.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum
  - PC_STEP=4
  - fetch_entry_t struct {instr, pc}
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push/pop/flush, count, full, empty. Flush wins over push/pop.

Test Plan:
1. Reset release, imem_req_ready=1, 1-cycle response latency, instr_ready=1. Required: addresses 0x0,0x4,0x8 issued on consecutive cycles; instr_pc sequence 0x0,0x4,0x8; instr_pc_plus4 = 0x4,0x8,0xC.
2. instr_ready=0 for 10 cycles. Required: after 2 responses imem_req_valid=0, instruction/instr_pc held stable. With instr_ready=1, every buffered word is delivered in order with none lost.
3. Setup: 2 requests outstanding at 0x10,0x14 with 3-cycle latency. Stimulus: redirect_valid=1 with target 0x100. Required: both responses dropped, instr_valid stays 0, next imem_req_addr=0x100, first instr_pc=0x100.
4. Stimulus: redirect on the same cycle as instr_valid&&instr_ready and a response arriving. Required: FIFO empty next cycle, kill counts only the remaining in-flight request, no stale instruction delivered.
5. Stimulus: PC=0xFFFF_FFFC accepted. Required: next imem_req_addr=0x0000_0000.
6. With FETCH_MISALIGN_TRAP_EN defined: redirect to 0x102 → misalign_err=1, no requests for 20 cycles; redirect to 0x200 → misalign_err=0, fetch from 0x200. Compiled out: redirect to 0x102 fetches 0x100.
